// File: rtl/sda_kernel_ctrl_axil_bridge.sv
// AXI4-Lite kernel control port to regReq/regAck register bus bridge.
// One register transaction at a time, each bounded by an acknowledge timeout.
module sda_kernel_ctrl_axil_bridge #(
    parameter int RegAddrWidth  = 12,
    parameter int TimeoutCycles = 64
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    ctrlAwValid,
    output logic                    ctrlAwReady,
    input  logic [RegAddrWidth-1:0] ctrlAwAddr,
    input  logic                    ctrlWValid,
    output logic                    ctrlWReady,
    input  logic [31:0]             ctrlWData,
    input  logic [3:0]              ctrlWStrb,
    output logic                    ctrlBValid,
    input  logic                    ctrlBReady,
    output logic [1:0]              ctrlBResp,
    input  logic                    ctrlArValid,
    output logic                    ctrlArReady,
    input  logic [RegAddrWidth-1:0] ctrlArAddr,
    output logic                    ctrlRValid,
    input  logic                    ctrlRReady,
    output logic [31:0]             ctrlRData,
    output logic [1:0]              ctrlRResp,
    output logic                    regReq,
    input  logic                    regAck,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic [31:0]             regRData
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [RegAddrWidth-1:0] AddrMask = ~(RegAddrWidth'(3));
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WRESP, RRESP} state_t;

    state_t                  state;
    logic                    lastWasWrite;
    logic [CntW-1:0]         toCnt;

    logic [RegAddrWidth-1:0] awAddrHold;
    logic [RegAddrWidth-1:0] arAddrHold;
    logic [31:0]             wDataHold;
    logic [3:0]              wStrbHold;
    logic                    awFull, wFull, arFull;

    logic awCap, wCap, arCap;
    logic timeoutHit, reqDone, clrWrite, clrRead;
    logic awFullNext, wFullNext, arFullNext;
    logic wrElig, rdElig, grantWrite;

    always_comb begin
        awCap      = ctrlAwValid & ctrlAwReady;
        wCap       = ctrlWValid & ctrlWReady;
        arCap      = ctrlArValid & ctrlArReady;
        timeoutHit = (toCnt == CntLast);
        reqDone    = (state == REQ) & (regAck | timeoutHit);
        clrWrite   = reqDone & regWriteEn;
        clrRead    = reqDone & ~regWriteEn;
        awFullNext = (awFull & ~clrWrite) | awCap;
        wFullNext  = (wFull & ~clrWrite) | wCap;
        arFullNext = (arFull & ~clrRead) | arCap;
        wrElig     = awFull & wFull;
        rdElig     = arFull;
        // On a tie the type not serviced last goes first.
        grantWrite = wrElig & (~rdElig | ~lastWasWrite);
    end

    always_ff @(posedge clk) begin
        if (awCap) awAddrHold <= ctrlAwAddr;
        if (wCap) begin
            wDataHold <= ctrlWData;
            wStrbHold <= ctrlWStrb;
        end
        if (arCap) arAddrHold <= ctrlArAddr;

        if (srst) begin
            awFull      <= 1'b0;
            wFull       <= 1'b0;
            arFull      <= 1'b0;
            ctrlAwReady <= 1'b0;
            ctrlWReady  <= 1'b0;
            ctrlArReady <= 1'b0;
        end else begin
            awFull      <= awFullNext;
            wFull       <= wFullNext;
            arFull      <= arFullNext;
            ctrlAwReady <= ~awFullNext;
            ctrlWReady  <= ~wFullNext;
            ctrlArReady <= ~arFullNext;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= IDLE;
            lastWasWrite <= 1'b0;
            toCnt        <= '0;
            regReq       <= 1'b0;
            regWriteEn   <= 1'b0;
            regAddr      <= '0;
            regWData     <= '0;
            regWStrb     <= '0;
            ctrlBValid   <= 1'b0;
            ctrlBResp    <= RespOkay;
            ctrlRValid   <= 1'b0;
            ctrlRResp    <= RespOkay;
            ctrlRData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (grantWrite) begin
                        regReq       <= 1'b1;
                        regWriteEn   <= 1'b1;
                        regAddr      <= awAddrHold & AddrMask;
                        regWData     <= wDataHold;
                        regWStrb     <= wStrbHold;
                        lastWasWrite <= 1'b1;
                        state        <= REQ;
                    end else if (rdElig) begin
                        regReq       <= 1'b1;
                        regWriteEn   <= 1'b0;
                        regAddr      <= arAddrHold & AddrMask;
                        regWData     <= '0;
                        regWStrb     <= '0;
                        lastWasWrite <= 1'b0;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (regAck || timeoutHit) begin
                        regReq <= 1'b0;
                        if (regWriteEn) begin
                            ctrlBValid <= 1'b1;
                            ctrlBResp  <= regAck ? RespOkay : RespSlvErr;
                            state      <= WRESP;
                        end else begin
                            ctrlRValid <= 1'b1;
                            ctrlRResp  <= regAck ? RespOkay : RespSlvErr;
                            ctrlRData  <= regAck ? regRData : 32'h0;
                            state      <= RRESP;
                        end
                    end else begin
                        toCnt <= toCnt + CntW'(1);
                    end
                end
                WRESP: begin
                    if (ctrlBReady) begin
                        ctrlBValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RRESP: begin
                    if (ctrlRReady) begin
                        ctrlRValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sda_kernel_ctrl_axil_bridge.sv
// Directed bench for sda_kernel_ctrl_axil_bridge with a parameter-RAM style
// responder (write ack at N+2, read ack at N+4) and a response scoreboard.
module tb_sda_kernel_ctrl_axil_bridge;

    logic        clk, srst;
    logic        ctrlAwValid, ctrlAwReady;
    logic [11:0] ctrlAwAddr;
    logic        ctrlWValid, ctrlWReady;
    logic [31:0] ctrlWData;
    logic [3:0]  ctrlWStrb;
    logic        ctrlBValid, ctrlBReady;
    logic [1:0]  ctrlBResp;
    logic        ctrlArValid, ctrlArReady;
    logic [11:0] ctrlArAddr;
    logic        ctrlRValid, ctrlRReady;
    logic [31:0] ctrlRData;
    logic [1:0]  ctrlRResp;
    logic        regReq, regAck, regWriteEn;
    logic [11:0] regAddr;
    logic [31:0] regWData, regRData;
    logic [3:0]  regWStrb;

    logic        slaveAck = 1'b0;
    logic        injAck;
    logic [31:0] slaveRData = 32'h0;
    assign regAck   = slaveAck | injAck;
    assign regRData = slaveRData;

    sda_kernel_ctrl_axil_bridge #(.RegAddrWidth(12), .TimeoutCycles(64)) dut (
        .clk(clk), .srst(srst),
        .ctrlAwValid(ctrlAwValid), .ctrlAwReady(ctrlAwReady), .ctrlAwAddr(ctrlAwAddr),
        .ctrlWValid(ctrlWValid), .ctrlWReady(ctrlWReady), .ctrlWData(ctrlWData), .ctrlWStrb(ctrlWStrb),
        .ctrlBValid(ctrlBValid), .ctrlBReady(ctrlBReady), .ctrlBResp(ctrlBResp),
        .ctrlArValid(ctrlArValid), .ctrlArReady(ctrlArReady), .ctrlArAddr(ctrlArAddr),
        .ctrlRValid(ctrlRValid), .ctrlRReady(ctrlRReady), .ctrlRData(ctrlRData), .ctrlRResp(ctrlRResp),
        .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn), .regAddr(regAddr),
        .regWData(regWData), .regWStrb(regWStrb), .regRData(regRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle monitor: per-request log of rise cycle, type, address, strobe and gap.
    int          cyc = 0;
    logic        prevReq = 1'b0, prevB = 1'b0, prevR = 1'b0;
    int          reqCount = 0;
    int          riseLog [0:255];
    int          gapLog  [0:255];
    logic        weLog   [0:255];
    logic [11:0] addrLog [0:255];
    logic [3:0]  strbLog [0:255];
    int          fallCyc = -1000, curLen = 0, lastLen = 0;
    int          bRiseCyc = 0, rRiseCyc = 0, rHsCyc = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prevReq <= regReq;
        prevB   <= ctrlBValid;
        prevR   <= ctrlRValid;
        if (regReq && !prevReq) begin
            riseLog[reqCount[7:0]] <= cyc;
            gapLog[reqCount[7:0]]  <= cyc - fallCyc;
            weLog[reqCount[7:0]]   <= regWriteEn;
            addrLog[reqCount[7:0]] <= regAddr;
            strbLog[reqCount[7:0]] <= regWStrb;
            reqCount <= reqCount + 1;
        end
        if (regReq) curLen <= prevReq ? curLen + 1 : 1;
        if (!regReq && prevReq) begin
            fallCyc <= cyc;
            lastLen <= curLen;
        end
        if (ctrlBValid && !prevB) bRiseCyc <= cyc;
        if (ctrlRValid && !prevR) rRiseCyc <= cyc;
        if (ctrlRValid && ctrlRReady) rHsCyc <= cyc;
    end

    // Parameter RAM responder; address 0x010 is left unmapped.
    logic [31:0] mem [0:1023];
    logic        pend = 1'b0;
    int          ackAt = 0;

    always @(posedge clk) begin
        slaveAck   <= 1'b0;
        slaveRData <= 32'h0;
        if (regReq && !prevReq && regAddr != 12'h010) begin
            pend  <= 1'b1;
            ackAt <= cyc + (regWriteEn ? 1 : 3);
        end
        if (pend && cyc == ackAt) begin
            pend     <= 1'b0;
            slaveAck <= 1'b1;
            if (regWriteEn) begin
                for (int b = 0; b < 4; b++)
                    if (regWStrb[b]) mem[regAddr[11:2]][8*b +: 8] <= regWData[8*b +: 8];
            end else begin
                slaveRData <= mem[regAddr[11:2]];
            end
        end
        if (srst) pend <= 1'b0;
    end

    typedef struct {
        bit          isWrite;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sendWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit awHs, wHs;
        ctrlAwAddr = addr; ctrlWData = data; ctrlWStrb = strb;
        ctrlAwValid = 1'b1; ctrlWValid = 1'b1;
        for (int i = 0; i < 100 && (ctrlAwValid || ctrlWValid); i++) begin
            @(posedge clk);
            awHs = ctrlAwValid && ctrlAwReady;
            wHs  = ctrlWValid && ctrlWReady;
            @(negedge clk);
            if (awHs) ctrlAwValid = 1'b0;
            if (wHs)  ctrlWValid  = 1'b0;
        end
        check("write_handshake", {ctrlAwValid, ctrlWValid}, 0);
        ctrlAwValid = 1'b0; ctrlWValid = 1'b0;
    endtask

    task automatic sendAr(input logic [11:0] addr);
        bit hs;
        ctrlArAddr = addr; ctrlArValid = 1'b1;
        for (int i = 0; i < 100 && ctrlArValid; i++) begin
            @(posedge clk);
            hs = ctrlArReady;
            @(negedge clk);
            if (hs) ctrlArValid = 1'b0;
        end
        check("ar_handshake", ctrlArValid, 0);
        ctrlArValid = 1'b0;
    endtask

    task automatic waitResp(input int hold, input bit inject);
        bit          found = 0;
        bit          isW;
        logic [1:0]  resp0;
        logic [31:0] data0;
        exp_t        e;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (ctrlBValid || ctrlRValid) found = 1;
        end
        check("resp_seen", found, 1);
        if (!found) return;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e   = sb.pop_front();
        isW = ctrlBValid;
        check("resp_type_is_write", isW, e.isWrite);
        if (isW) begin
            check("bresp", ctrlBResp, e.resp);
        end else begin
            check("rresp", ctrlRResp, e.resp);
            check("rdata", ctrlRData, e.data);
        end
        resp0 = isW ? ctrlBResp : ctrlRResp;
        data0 = ctrlRData;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", isW ? ctrlBValid : ctrlRValid, 1);
            check("hold_resp", isW ? ctrlBResp : ctrlRResp, resp0);
            check("hold_rdata", ctrlRData, data0);
            check("hold_no_req", regReq, 0);
            injAck = inject && (i == 2);
        end
        injAck = 1'b0;
        if (isW) ctrlBReady = 1'b1; else ctrlRReady = 1'b1;
        @(negedge clk);
        ctrlBReady = 1'b0; ctrlRReady = 1'b0;
        check("valid_drop", {ctrlBValid, ctrlRValid}, 0);
    endtask

    initial begin
        int base;
        srst = 1'b1; injAck = 1'b0;
        ctrlAwValid = 0; ctrlAwAddr = 0; ctrlWValid = 0; ctrlWData = 0; ctrlWStrb = 0;
        ctrlBReady = 0; ctrlArValid = 0; ctrlArAddr = 0; ctrlRReady = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {ctrlAwReady, ctrlWReady, ctrlArReady, ctrlBValid, ctrlRValid, regReq, regWriteEn}, 0);
        check("rst_resp", {ctrlBResp, ctrlRResp}, 0);
        check("rst_rdata", ctrlRData, 0);
        check("rst_regaddr", regAddr, 0);
        check("rst_regwdata", regWData, 0);
        check("rst_regwstrb", regWStrb, 0);
        srst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {ctrlAwReady, ctrlWReady, ctrlArReady}, 3'b111);

        // Basic write then readback against the parameter RAM.
        base = reqCount;
        sb.push_back('{1'b1, 2'b00, 32'h0});
        sendWrite(12'h040, 32'hA5A5_1234, 4'hF);
        waitResp(0, 0);
        check("wr_req_count", reqCount - base, 1);
        check("wr_we", weLog[base], 1);
        check("wr_addr", addrLog[base], 12'h040);
        check("wr_req_len", lastLen, 3);
        check("wr_b_latency", bRiseCyc - riseLog[base], 3);

        base = reqCount;
        sb.push_back('{1'b0, 2'b00, 32'hA5A5_1234});
        sendAr(12'h040);
        waitResp(0, 0);
        check("rd_we", weLog[base], 0);
        check("rd_strb", strbLog[base], 0);
        check("rd_req_len", lastLen, 5);
        check("rd_r_latency", rRiseCyc - riseLog[base], 5);

        // AW at 0, AR at 2, W at 5: read goes first.
        base = reqCount;
        sb.push_back('{1'b0, 2'b00, 32'hA5A5_1234});
        sb.push_back('{1'b1, 2'b00, 32'h0});
        @(negedge clk); ctrlAwAddr = 12'h080; ctrlAwValid = 1'b1;
        check("t3_awready", ctrlAwReady, 1);
        @(negedge clk); ctrlAwValid = 1'b0;
        @(negedge clk); ctrlArAddr = 12'h040; ctrlArValid = 1'b1;
        check("t3_arready", ctrlArReady, 1);
        @(negedge clk); ctrlArValid = 1'b0;
        @(negedge clk);
        @(negedge clk); ctrlWData = 32'h1111_2222; ctrlWStrb = 4'hF; ctrlWValid = 1'b1;
        check("t3_wready", ctrlWReady, 1);
        @(negedge clk); ctrlWValid = 1'b0;
        waitResp(0, 0);
        waitResp(0, 0);
        check("t3_first_is_read", weLog[base], 0);
        check("t3_second_is_write", weLog[base + 1], 1);
        check("t3_write_after_rresp", riseLog[base + 1] > rHsCyc, 1);
        check("t3_gap_ge2", gapLog[base + 1] >= 2, 1);

        // Simultaneous read and write after a write: read wins.
        base = reqCount;
        sb.push_back('{1'b0, 2'b00, 32'h1111_2222});
        sb.push_back('{1'b1, 2'b00, 32'h0});
        @(negedge clk);
        ctrlAwAddr = 12'h0C0; ctrlWData = 32'h0BAD_F00D; ctrlWStrb = 4'hF; ctrlArAddr = 12'h080;
        ctrlAwValid = 1'b1; ctrlWValid = 1'b1; ctrlArValid = 1'b1;
        @(negedge clk);
        ctrlAwValid = 1'b0; ctrlWValid = 1'b0; ctrlArValid = 1'b0;
        waitResp(0, 0);
        waitResp(0, 0);
        check("tie_read_first", weLog[base], 0);
        check("tie_gap_ge2", gapLog[base + 1] >= 2, 1);

        // Read timeout on unmapped address, then a late acknowledge.
        base = reqCount;
        sb.push_back('{1'b0, 2'b10, 32'h0});
        sendAr(12'h010);
        waitResp(5, 1);
        check("to_req_len", lastLen, 64);
        repeat (2) @(negedge clk);
        injAck = 1'b1;
        @(negedge clk);
        injAck = 1'b0;
        repeat (3) @(negedge clk);
        check("to_late_ack_no_req", reqCount - base, 1);
        check("to_late_ack_no_valid", {ctrlBValid, ctrlRValid, regReq}, 0);

        // B response back-pressure with a read queued behind it.
        base = reqCount;
        sb.push_back('{1'b1, 2'b00, 32'h0});
        sb.push_back('{1'b0, 2'b00, 32'h0BAD_0123});
        sendWrite(12'h0C0, 32'h0BAD_0123, 4'hF);
        sendAr(12'h0C0);
        waitResp(10, 0);
        waitResp(0, 0);
        check("bp_two_reqs", reqCount - base, 2);

        // Reset in the middle of REQ, then a fresh unaligned partial write.
        sendWrite(12'h010, 32'hFFFF_FFFF, 4'hF);
        repeat (4) @(negedge clk);
        check("mid_req_active", regReq, 1);
        srst = 1'b1;
        @(negedge clk);
        check("srst_clears", {regReq, ctrlBValid, ctrlRValid, ctrlAwReady, ctrlWReady, ctrlArReady}, 0);
        srst = 1'b0;
        @(negedge clk);
        check("srst_ready_back", {ctrlAwReady, ctrlWReady, ctrlArReady}, 3'b111);
        base = reqCount;
        sb.push_back('{1'b1, 2'b00, 32'h0});
        sendWrite(12'h042, 32'hDEAD_BEEF, 4'h3);
        waitResp(0, 0);
        check("post_rst_addr_aligned", addrLog[base], 12'h040);
        check("post_rst_strb", strbLog[base], 4'h3);
        check("post_rst_b_latency", bRiseCyc - riseLog[base], 3);
        sb.push_back('{1'b0, 2'b00, 32'hA5A5_BEEF});
        sendAr(12'h040);
        waitResp(0, 0);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
